// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage data memory responder.
package mem_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } mem_state_t;

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x 32 word array: synchronous write, asynchronous read, contents not reset.
module data_mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WORD_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WORD_W-1:0]        rdata
);

  typedef logic [WORD_W-1:0] mem_t [DEPTH];

  // Simulation-only preload: word i holds i, matching the register file convention.
  function automatic mem_t init_words();
    mem_t m;
    for (int i = 0; i < int'(DEPTH); i++) begin
      m[i] = WORD_W'(i);
    end
    return m;
  endfunction

  mem_t mem = init_words();

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder: one request at a time, fixed access latency,
// one-cycle response strobe and a stall towards pipeline control.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              addr_err,
  output logic              mem_stall
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = ($clog2(LATENCY + 1) < 1) ? 1 : $clog2(LATENCY + 1);

  mem_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [AW-1:0]     idx_q;
  logic              misal_q;
  logic              write_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              err_q;
  logic [WORD_W-1:0] arr_rdata;
  logic              accept;
  logic              access;
  logic              arr_we;

  // Address bits above the word index wrap and are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];

  assign accept = (state_q == IDLE) && req_valid;
  assign access = (state_q == BUSY) && (cnt_q == '0);
  assign arr_we = access && write_q && !misal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    mem_stall  = accept || (state_q == BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      misal_q <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q   <= CW'(LATENCY - 1);
        idx_q   <= req_addr[AW+1:2];
        misal_q <= (req_addr[1:0] != 2'b00);
        write_q <= req_write;
        wdata_q <= req_wdata;
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
      // Response data and error are held from one access to the next.
      if (access) begin
        rdata_q <= (write_q || misal_q) ? '0 : arr_rdata;
        err_q   <= misal_q;
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign addr_err   = err_q;

  data_mem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .waddr(idx_q),
    .wdata(wdata_q),
    .raddr(idx_q),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random traffic against a word-array model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        addr_err;
  logic        mem_stall;

  int          total;
  int          bad;
  int          cyc;
  logic [31:0] model [DEPTH];

  data_mem_responder #(
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .addr_err  (addr_err),
    .mem_stall (mem_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One request; optionally keep req_valid high afterwards carrying the next request.
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input bit hold, input bit nw, input logic [31:0] na,
                     input logic [31:0] nd, output logic [31:0] got, output int acc);
    bit          mis;
    int          idx;
    logic [31:0] exp_r;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    #1;
    chk("idle_ready", req_ready, 1);
    chk("idle_no_resp", resp_valid, 0);
    chk("accept_stall", mem_stall, 1);
    acc   = cyc;
    mis   = (a % 4) != 0;
    idx   = int'((a / 4) % DEPTH);
    exp_r = (mis || w) ? 32'h0 : model[idx];
    if (w && !mis) model[idx] = d;
    @(posedge clk);
    #1;
    if (hold) begin
      req_write = nw;
      req_addr  = na;
      req_wdata = nd;
    end else begin
      req_valid = 1'b0;
    end
    for (int k = 0; k < int'(LATENCY); k++) begin
      @(negedge clk);
      chk("busy_ready", req_ready, 0);
      chk("busy_stall", mem_stall, 1);
      chk("busy_no_resp", resp_valid, 0);
    end
    @(negedge clk);
    chk("resp_valid", resp_valid, 1);
    chk("resp_rdata", resp_rdata, exp_r);
    chk("resp_err", addr_err, {31'b0, mis});
    chk("resp_stall", mem_stall, 0);
    chk("resp_ready", req_ready, 0);
    got = resp_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got;
    int          acc0;
    int          acc1;
    logic [31:0] a;
    bit          w;
    total = 0;
    bad   = 0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = i;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_stall", mem_stall, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_resp_valid", resp_valid, 0);
    chk("post_rst_rdata", resp_rdata, 0);
    chk("post_rst_err", addr_err, 0);
    chk("post_rst_stall", mem_stall, 0);

    // Load 0x10 returns word 4.
    txn(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, got, acc0);
    chk("load_0x10", got, 32'd4);

    // Store, load back, then load through an aliasing address.
    txn(1'b1, 32'h20, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0, got, acc0);
    txn(1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, got, acc0);
    chk("load_0x20", got, 32'hDEADBEEF);
    txn(1'b0, 32'h420, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, got, acc0);
    chk("load_wrap_0x420", got, 32'hDEADBEEF);

    // Misaligned store must not touch word 8.
    txn(1'b1, 32'h22, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0, got, acc0);
    chk("misal_rdata", got, 32'h0);
    txn(1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, got, acc0);
    chk("after_misal_load", got, 32'hDEADBEEF);

    // Reset during BUSY discards the pending store.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", mem_stall, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_rdata", resp_rdata, 0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_hold_resp", resp_valid, 0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("after_rst_no_resp", resp_valid, 0);
      chk("after_rst_ready", req_ready, 1);
    end
    txn(1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, got, acc0);
    chk("load_after_rst", got, 32'd12);

    // Back-to-back: store then load held on a continuous req_valid.
    txn(1'b1, 32'h44, 32'hA5A50F0F, 1'b1, 1'b0, 32'h44, 32'h0, got, acc0);
    txn(1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, got, acc1);
    chk("b2b_spacing", acc1 - acc0, LATENCY + 2);
    chk("b2b_load", got, 32'hA5A50F0F);
    @(negedge clk);
    chk("b2b_resp_width", resp_valid, 0);

    // Random traffic over a small window so stores and loads collide, with aliasing and misalignment.
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 7) << 10) | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 3) == 0) a = a | $urandom_range(1, 3);
      w = 1'($urandom_range(0, 1));
      txn(w, a, $urandom, 1'b0, 1'b0, 32'h0, 32'h0, got, acc0);
    end

    @(negedge clk);
    chk("final_idle_ready", req_ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
